aes_tlul_host_arb: RTL
======================

// Module: aes_tlul_host_arb
// PURPOSE
//  Round-robin arbiter sharing the single AES TL-UL register port (tl_i/tl_o) between NUM_REQ hosts.
//  Each host issues PutFullData (opcode 0) or Get (opcode 4) on its own A/D channel pair.
//  Exactly one transaction is outstanding at the AES port at any time.
//  A response timeout returns an error to the owning host so that a hung access cannot stall the bus.
// PARAMETERS
//  NUM_REQ     2   number of requesting hosts (>=2)
//  ADDR_WIDTH  32  A-channel address width
//  DATA_WIDTH  32  A/D-channel data width
//  TIMEOUT     64  max cycles in RESP before synthesising an error response; 0 disables the timeout
// PORTS
//  clk_i        in   1                    clock
//  rst_ni       in   1                    synchronous active-low reset
//  h_a_valid    in   NUM_REQ              per-host request valid
//  h_a_opcode   in   NUM_REQ*3            per-host opcode (0 write, 4 read)
//  h_a_address  in   NUM_REQ*ADDR_WIDTH   per-host address
//  h_a_data     in   NUM_REQ*DATA_WIDTH   per-host write data
//  h_a_ready    out  NUM_REQ              per-host request accepted (one-hot or zero)
//  h_d_valid    out  NUM_REQ              per-host response valid (one-hot or zero)
//  h_d_data     out  DATA_WIDTH           response data (shared; qualify with h_d_valid)
//  h_d_error    out  1                    response error (shared)
//  h_d_ready    in   NUM_REQ              per-host response ready
//  a_valid/a_opcode/a_address/a_data  out  1/3/ADDR_WIDTH/DATA_WIDTH  to AES tl_i
//  a_ready      in   1                    from AES tl_o
//  d_valid      in   1                    from AES tl_o
//  d_data       in   DATA_WIDTH           from AES tl_o
//  d_error      in   1                    from AES tl_o
//  d_ready      out  1                    to AES tl_i
// BEHAVIOUR
//  - Reset (rst_ni=0 at a clk_i edge): state=IDLE; grant=0; rr_ptr=0; tmo_cnt=0.
//    All outputs are 0: a_valid, h_a_ready, h_d_valid, d_ready, h_d_data, h_d_error.
//    Reset mid-transaction abandons the transaction; the AES port is assumed reset together with this block.
//  - FSM states: IDLE, ADDR, RESP, ERR, DRAIN.
//  - IDLE: if any h_a_valid is set, pick the first requester at or after rr_ptr (wrapping modulo NUM_REQ).
//    Register the winner in grant and go to ADDR on the next edge (1 cycle arbitration latency).
//  - ADDR: a_* = granted host's h_a_* (combinational mux); a_valid=1.
//    h_a_ready[grant] = a_ready. On a_valid&a_ready go to RESP and clear tmo_cnt.
//    Hosts must hold A-channel signals stable until accepted.
//  - RESP: d_ready = h_d_ready[grant]; h_d_valid[grant] = d_valid; h_d_data/h_d_error pass through.
//    On d_valid&d_ready: rr_ptr = (grant+1) mod NUM_REQ, go to IDLE.
//    Otherwise tmo_cnt increments (saturating). If TIMEOUT!=0 and tmo_cnt==TIMEOUT-1 with no handshake, go to ERR.
//  - ERR: h_d_valid[grant]=1, h_d_data=0, h_d_error=1, d_ready=0.
//    On h_d_ready[grant]: update rr_ptr as in RESP, go to DRAIN.
//  - DRAIN: d_ready=1; no host is granted. On d_valid, discard the late response and go to IDLE.
//  - A host gets no new grant in the cycle its response completes: IDLE always costs one cycle.
//  - Simultaneous requests: the round-robin pointer guarantees each host is served within NUM_REQ transactions.
//  - Opcodes are forwarded unchanged; the AES responds to illegal opcodes with d_error.
//  - Non-granted hosts always see h_a_ready=0 and h_d_valid=0.
// TESTING
//  1. Single write: host0 a_valid, op 0, addr 0x04, data 0xDEADBEEF; AES a_ready=1, d_valid 2 cycles later -> a_valid in cycle 1, h_d_valid[0] with error 0, h_a_ready[1] never set.
//  2. Contention: both hosts request continuously, 4 transactions -> grant order 0,1,0,1; rr_ptr wraps 1->0.
//  3. Backpressure: a_ready low 5 cycles, then h_d_ready[1] low 3 cycles -> a_* stable throughout; d_ready follows h_d_ready[1]; no transfer is lost.
//  4. Timeout (TIMEOUT=8): AES never asserts d_valid -> h_d_error=1, h_d_data=0 after 8 RESP cycles; late d_valid in DRAIN is absorbed; next grant proceeds normally.
//  5. Reset mid-RESP: rst_ni=0 for one edge -> all outputs 0 in the next cycle; state IDLE; rr_ptr=0; next request goes to host0.

Source files
------------

// File: rtl/aes_tlul_host_arb.sv
// Round-robin arbiter sharing one AES TL-UL register port between NUM_REQ hosts.
// One transaction is outstanding at a time; a response timeout returns an error
// to the owning host and the late AES response is absorbed afterwards.
module aes_tlul_host_arb #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  // host side
  input  logic [NUM_REQ-1:0]              h_a_valid,
  input  logic [NUM_REQ*3-1:0]            h_a_opcode,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   h_a_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   h_a_data,
  output logic [NUM_REQ-1:0]              h_a_ready,
  output logic [NUM_REQ-1:0]              h_d_valid,
  output logic [DATA_WIDTH-1:0]           h_d_data,
  output logic                            h_d_error,
  input  logic [NUM_REQ-1:0]              h_d_ready,
  // AES side
  output logic                            a_valid,
  output logic [2:0]                      a_opcode,
  output logic [ADDR_WIDTH-1:0]           a_address,
  output logic [DATA_WIDTH-1:0]           a_data,
  input  logic                            a_ready,
  input  logic                            d_valid,
  input  logic [DATA_WIDTH-1:0]           d_data,
  input  logic                            d_error,
  output logic                            d_ready
);

  localparam int unsigned GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW       = $clog2(TIMEOUT + 2);
  localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_RESP  = 3'd2,
    ST_ERR   = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  state_e          r_state;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   r_rr_ptr;
  logic [TW-1:0]   r_tmo_cnt;

  logic            w_any;
  logic [GW-1:0]   w_pick;
  logic [GW-1:0]   w_next_ptr;
  int unsigned     w_idx;

  // First requester at or after the round-robin pointer, wrapping modulo NUM_REQ
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = 32'(r_rr_ptr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_any && h_a_valid[w_idx]) begin
        w_any  = 1'b1;
        w_pick = GW'(w_idx);
      end
    end
  end

  // Pointer moves to the host after the one just served
  assign w_next_ptr = (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + GW'(1);

  // Arbitration FSM, grant, round-robin pointer and response timeout counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_tmo_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (a_ready) begin
            r_tmo_cnt <= '0;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (d_valid && h_d_ready[r_grant]) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_IDLE;
          end else begin
            if (TIMEOUT != 0 && r_tmo_cnt == TW'(TMO_LAST)) r_state <= ST_ERR;
            if (r_tmo_cnt != {TW{1'b1}}) r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        ST_ERR: begin
          if (h_d_ready[r_grant]) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (d_valid) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Channel steering: only the granted host ever sees ready/valid
  always_comb begin
    a_valid   = 1'b0;
    a_opcode  = '0;
    a_address = '0;
    a_data    = '0;
    d_ready   = 1'b0;
    h_a_ready = '0;
    h_d_valid = '0;
    h_d_data  = '0;
    h_d_error = 1'b0;
    case (r_state)
      ST_ADDR: begin
        a_valid            = 1'b1;
        a_opcode           = h_a_opcode[int'(r_grant)*3 +: 3];
        a_address          = h_a_address[int'(r_grant)*ADDR_WIDTH +: ADDR_WIDTH];
        a_data             = h_a_data[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
        h_a_ready[r_grant] = a_ready;
      end
      ST_RESP: begin
        d_ready            = h_d_ready[r_grant];
        h_d_valid[r_grant] = d_valid;
        h_d_data           = d_data;
        h_d_error          = d_error;
      end
      ST_ERR: begin
        h_d_valid[r_grant] = 1'b1;
        h_d_error          = 1'b1;
      end
      ST_DRAIN: begin
        d_ready = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
